// File: rtl/div_ctrl.sv
// div_ctrl -- sequencing controller between the execute stage and the
// iterative unsigned 32-bit divider engine. Owns the architectural HI/LO
// registers, performs signed fix-up of engine results, interlocks MFHI/MFLO
// reads while a divide is in flight and recovers from divide-by-zero and
// engine timeout without disturbing HI/LO.
//
// Optional build macro: DIV_CTRL_FASTPATH_EN
//   When defined, a divide whose dividend magnitude is below the divisor
//   magnitude completes in IDLE (lo=0, hi=dividend) without using the engine.
module div_ctrl #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        req_ready,
  input  logic        mf_req,
  output logic        mf_stall,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        div0,
  output logic        timeout_err,
  output logic        eng_start,
  output logic [31:0] eng_a,
  output logic [31:0] eng_b,
  input  logic        eng_done,
  input  logic [31:0] eng_q,
  input  logic [31:0] eng_r
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LAUNCH = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_FIXUP  = 2'd3;

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_DIV  = 3'd1;
  localparam logic [2:0] OP_DIVU = 3'd2;
  localparam logic [2:0] OP_MTHI = 3'd3;
  localparam logic [2:0] OP_MTLO = 3'd4;

  logic [1:0]        state;
  logic [CNT_W-1:0]  wait_cnt;

  // Operand attributes of the divide in flight, used at fix-up time.
  logic              signed_op;
  logic              sign_a;
  logic              sign_q;
  logic [31:0]       q_cap;
  logic [31:0]       r_cap;

  logic signed [31:0] req_a_s;
  logic signed [31:0] req_b_s;
  logic [31:0]        mag_a;
  logic [31:0]        mag_b;
  logic               op_div_signed;
  logic               op_div_any;
  logic               op_clears_div0;
  logic               accept;
  logic               div_by_zero;
  logic               fast_hit;

  // Two's-complement magnitude as an unsigned value; 0x80000000 maps onto
  // itself, which is exactly 2^31 when read as unsigned.
  function automatic logic [31:0] magnitude(input logic signed [31:0] v);
    logic [31:0] u;
    u = v;
    return v[31] ? (~u + 32'd1) : u;
  endfunction

  // Conditional negation mod 2^32 for the sign fix-up of quotient/remainder.
  function automatic logic [31:0] negate_if(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

  assign req_a_s = req_a;
  assign req_b_s = req_b;

  // Request decode and operand magnitude preparation for the engine.
  always_comb begin
    op_div_signed  = (req_op == OP_DIV);
    op_div_any     = (req_op == OP_DIV) || (req_op == OP_DIVU);
    op_clears_div0 = (req_op != OP_NOP) && (req_op <= OP_MTLO);
    accept         = req_valid && (state == S_IDLE);
    div_by_zero    = (req_b == 32'd0);
    mag_a          = op_div_signed ? magnitude(req_a_s) : req_a;
    mag_b          = op_div_signed ? magnitude(req_b_s) : req_b;
`ifdef DIV_CTRL_FASTPATH_EN
    fast_hit       = (mag_a < mag_b);
`else
    fast_hit       = 1'b0;
`endif
  end

  assign req_ready = (state == S_IDLE);
  assign mf_stall  = mf_req && (state != S_IDLE);

  // Control FSM plus architectural HI/LO, status flags and engine launch.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      wait_cnt    <= '0;
      hi          <= '0;
      lo          <= '0;
      div0        <= 1'b0;
      timeout_err <= 1'b0;
      eng_start   <= 1'b0;
      eng_a       <= '0;
      eng_b       <= '0;
    end else begin
      eng_start   <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (op_clears_div0) begin
              div0 <= 1'b0;
            end
            case (req_op)
              OP_MTHI: hi <= req_a;
              OP_MTLO: lo <= req_a;
              OP_DIV, OP_DIVU: begin
                if (div_by_zero) begin
                  div0 <= 1'b1;
                end else if (fast_hit) begin
                  lo <= '0;
                  hi <= req_a;
                end else begin
                  eng_a     <= mag_a;
                  eng_b     <= mag_b;
                  eng_start <= 1'b1;
                  state     <= S_LAUNCH;
                end
              end
              default: ;
            endcase
          end
        end
        S_LAUNCH: begin
          wait_cnt <= '0;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          // A result arriving on the last allowed cycle still wins.
          if (eng_done) begin
            state <= S_FIXUP;
          end else if (wait_cnt == CNT_LAST) begin
            timeout_err <= 1'b1;
            state       <= S_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_FIXUP: begin
          lo    <= negate_if(q_cap, signed_op && sign_q);
          hi    <= negate_if(r_cap, signed_op && sign_a);
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Divide context and engine result capture; these only feed fix-up and
  // are always rewritten before use, so they carry no reset.
  always_ff @(posedge clk) begin
    if (accept && op_div_any) begin
      signed_op <= op_div_signed;
      sign_a    <= req_a[31];
      sign_q    <= req_a[31] ^ req_b[31];
    end
    if ((state == S_WAIT) && eng_done) begin
      q_cap <= eng_q;
      r_cap <= eng_r;
    end
  end

endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl: a bench-side engine responder, a
// transaction-level reference model and a per-cycle compare process,
// followed by directed corner cases and a randomized phase.
module tb_div_ctrl;

  localparam int TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic [2:0]  req_op = 3'd0;
  logic [31:0] req_a = 32'd0;
  logic [31:0] req_b = 32'd0;
  logic        req_ready;
  logic        mf_req = 1'b0;
  logic        mf_stall;
  logic [31:0] hi, lo;
  logic        div0, timeout_err, eng_start;
  logic [31:0] eng_a, eng_b;
  logic        eng_done = 1'b0;
  logic [31:0] eng_q = 32'd0;
  logic [31:0] eng_r = 32'd0;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  div_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .mf_req(mf_req), .mf_stall(mf_stall),
    .hi(hi), .lo(lo), .div0(div0), .timeout_err(timeout_err),
    .eng_start(eng_start), .eng_a(eng_a), .eng_b(eng_b),
    .eng_done(eng_done), .eng_q(eng_q), .eng_r(eng_r)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  // ---------------- engine responder ----------------
  logic        st_s, rdy_s;
  logic [31:0] a_s, b_s;
  int          eng_pending = 0;
  int          eng_cnt = 0;
  int          starts = 0;
  logic [31:0] last_a = 32'd0, last_b = 32'd0;
  bit          force_set = 0;
  int          force_val = 0;
  bit          spurious_en = 0;

  always @(negedge clk) begin
    st_s  = eng_start;
    rdy_s = req_ready;
    a_s   = eng_a;
    b_s   = eng_b;
  end

  always @(posedge clk) begin
    int lat;
    #2;
    eng_done = 1'b0;
    if (st_s === 1'b1) begin
      starts++;
      last_a = a_s;
      last_b = b_s;
      if (force_set) begin
        lat = force_val;
        force_set = 0;
      end else if ($urandom_range(0, 99) < 5) begin
        lat = -1;
      end else begin
        lat = $urandom_range(0, 45);
      end
      if (lat >= 0) begin
        eng_pending = 1;
        eng_cnt = lat;
      end
    end
    if (eng_pending != 0) begin
      if (eng_cnt == 0) begin
        eng_done = 1'b1;
        eng_q = (last_b == 0) ? 32'd0 : last_a / last_b;
        eng_r = (last_b == 0) ? 32'd0 : last_a % last_b;
        eng_pending = 0;
      end else begin
        eng_cnt--;
      end
    end else if (st_s !== 1'b1 && spurious_en && rdy_s === 1'b1 &&
                 $urandom_range(0, 19) == 0) begin
      eng_done = 1'b1;
      eng_q = $urandom;
      eng_r = $urandom;
    end
  end

  // ---------------- reference model ----------------
  bit          m_busy = 0, m_wr = 0, m_div0 = 0, m_terr = 0;
  int          m_age = 0;
  logic [31:0] m_hi = 0, m_lo = 0, m_rhi = 0, m_rlo = 0, m_ea = 0, m_eb = 0;
  longint      sa, sb, ma, mb, lq, lr;

  always @(posedge clk) begin
    m_terr = 0;
    if (reset) begin
      m_busy = 0; m_wr = 0; m_hi = 0; m_lo = 0; m_div0 = 0;
      m_ea = 0; m_eb = 0; m_age = 0;
    end else if (!m_busy) begin
      if (req_valid) begin
        case (req_op)
          3'd3: begin m_hi = req_a; m_div0 = 0; end
          3'd4: begin m_lo = req_a; m_div0 = 0; end
          3'd1, 3'd2: begin
            m_div0 = 0;
            if (req_b == 0) begin
              m_div0 = 1;
            end else begin
              if (req_op == 3'd1) begin
                sa = longint'($signed(req_a));
                sb = longint'($signed(req_b));
              end else begin
                sa = longint'(req_a);
                sb = longint'(req_b);
              end
              ma = (sa < 0) ? -sa : sa;
              mb = (sb < 0) ? -sb : sb;
              lq = sa / sb;
              lr = sa % sb;
`ifdef DIV_CTRL_FASTPATH_EN
              if (ma < mb) begin
                m_hi = req_a;
                m_lo = 0;
              end else
`endif
              begin
                m_busy = 1; m_age = 0; m_wr = 0;
                m_ea = ma[31:0]; m_eb = mb[31:0];
                m_rlo = lq[31:0]; m_rhi = lr[31:0];
              end
            end
          end
          default: ;
        endcase
      end
    end else if (m_wr) begin
      m_hi = m_rhi; m_lo = m_rlo; m_busy = 0; m_wr = 0;
    end else if (m_age == 0) begin
      m_age = 1;
    end else if (eng_done) begin
      m_wr = 1;
    end else if (m_age == TIMEOUT) begin
      m_busy = 0; m_terr = 1;
    end else begin
      m_age++;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    chk("req_ready", 32'(req_ready), 32'(!m_busy));
    chk("mf_stall", 32'(mf_stall), 32'(mf_req && m_busy));
    chk("hi", hi, m_hi);
    chk("lo", lo, m_lo);
    chk("div0", 32'(div0), 32'(m_div0));
    chk("timeout_err", 32'(timeout_err), 32'(m_terr));
    chk("eng_start", 32'(eng_start), 32'(m_busy && !m_wr && m_age == 0));
    chk("eng_a", eng_a, m_ea);
    chk("eng_b", eng_b, m_eb);
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #2;
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    @(posedge clk); #2;
    req_valid = 1'b0; req_op = 3'd0;
  endtask

  task automatic wait_ready(input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (req_ready !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (req_ready !== 1'b1) chk("wait_ready_bound", 32'(req_ready), 32'd1);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      4: return 32'hFFFF_FFFF - 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int s0, t0, t1, n;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    chk("reset_ready", 32'(req_ready), 32'd1);
    chk("reset_start", 32'(eng_start), 32'd0);

    // DIVU 100/7, engine answers 33 cycles after launch
    s0 = starts;
    force_set = 1; force_val = 32;
    send(3'd2, 32'd100, 32'd7);
    wait_ready(200);
    chk("divu_lo", lo, 32'd14);
    chk("divu_hi", hi, 32'd2);
    chk("divu_starts", 32'(starts - s0), 32'd1);
    chk("divu_eng_a", last_a, 32'd100);
    chk("divu_eng_b", last_b, 32'd7);

    // DIV -7/2
    force_set = 1; force_val = 5;
    send(3'd1, 32'hFFFF_FFF9, 32'd2);
    wait_ready(200);
    chk("div_neg_eng_a", last_a, 32'd7);
    chk("div_neg_eng_b", last_b, 32'd2);
    chk("div_neg_lo", lo, 32'hFFFF_FFFD);
    chk("div_neg_hi", hi, 32'hFFFF_FFFF);

    // DIV 0x80000000 / -1
    force_set = 1; force_val = 3;
    send(3'd1, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_ready(200);
    chk("div_min_eng_a", last_a, 32'h8000_0000);
    chk("div_min_eng_b", last_b, 32'd1);
    chk("div_min_lo", lo, 32'h8000_0000);
    chk("div_min_hi", hi, 32'd0);

    // DIVU 5/0 then MTLO
    s0 = starts;
    send(3'd2, 32'd5, 32'd0);
    @(negedge clk);
    chk("div0_flag", 32'(div0), 32'd1);
    chk("div0_lo", lo, 32'h8000_0000);
    chk("div0_hi", hi, 32'd0);
    chk("div0_starts", 32'(starts - s0), 32'd0);
    send(3'd4, 32'h1234, 32'd0);
    @(negedge clk);
    chk("mtlo_div0", 32'(div0), 32'd0);
    chk("mtlo_lo", lo, 32'h1234);

    // engine never answers
    force_set = 1; force_val = -1;
    send(3'd2, 32'd9, 32'd3);
    n = 0;
    while (eng_start !== 1'b1 && n < 5) begin @(negedge clk); n++; end
    t0 = cyc;
    n = 0;
    while (timeout_err !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    t1 = cyc;
    chk("timeout_seen", 32'(timeout_err), 32'd1);
    chk("timeout_delay", 32'(t1 - t0), 32'(TIMEOUT + 1));
    chk("timeout_hi", hi, 32'd0);
    chk("timeout_lo", lo, 32'h1234);
    @(negedge clk);
    chk("timeout_pulse_end", 32'(timeout_err), 32'd0);
    chk("timeout_ready", 32'(req_ready), 32'd1);

    // reset in WAIT with a read pending, late eng_done afterwards
    force_set = 1; force_val = 40;
    send(3'd2, 32'd1000, 32'd3);
    repeat (10) @(posedge clk);
    #2 mf_req = 1'b1;
    @(negedge clk);
    chk("wait_mf_stall", 32'(mf_stall), 32'd1);
    @(posedge clk); #2 reset = 1'b1;
    @(posedge clk); #2 reset = 1'b0;
    @(negedge clk);
    chk("rst_mf_stall", 32'(mf_stall), 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd1);
    n = 0;
    while (eng_pending != 0 && n < 100) begin @(negedge clk); n++; end
    chk("late_done_fired", 32'(eng_pending), 32'd0);
    repeat (2) @(negedge clk);
    chk("late_done_hi", hi, 32'd0);
    chk("late_done_lo", lo, 32'd0);
    mf_req = 1'b0;

    // small quotient: fast path when enabled, engine otherwise
    s0 = starts;
    force_set = 1; force_val = 2;
    send(3'd2, 32'd3, 32'd10);
`ifdef DIV_CTRL_FASTPATH_EN
    @(negedge clk);
    chk("fast_lo", lo, 32'd0);
    chk("fast_hi", hi, 32'd3);
    chk("fast_starts", 32'(starts - s0), 32'd0);
    force_set = 0;
`else
    wait_ready(200);
    chk("small_lo", lo, 32'd0);
    chk("small_hi", hi, 32'd3);
    chk("small_starts", 32'(starts - s0), 32'd1);
`endif

    // randomized traffic
    spurious_en = 1;
    for (int i = 0; i < 2500; i++) begin
      @(posedge clk); #2;
      req_valid = ($urandom_range(0, 9) < 7);
      req_op    = 3'($urandom_range(0, 7));
      req_a     = pick();
      req_b     = ($urandom_range(0, 9) == 0) ? 32'd0 : pick();
      mf_req    = 1'($urandom_range(0, 1));
    end
    @(posedge clk); #2;
    req_valid = 1'b0; req_op = 3'd0; mf_req = 1'b0;
    wait_ready(200);
    spurious_en = 0;
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/div_ctrl.md
Name: div_ctrl

Overview:
- Sequencing controller between the CPU execute stage and the iterative 32-bit divider engine.
- Accepts DIV, DIVU, MTHI and MTLO requests and owns the architectural HI/LO registers.
- For signed divides, sends operand magnitudes to the unsigned engine, applies sign fix-up to the results, and interlocks MFHI/MFLO reads while a divide is in flight.
- Handles divide-by-zero and engine timeout without touching HI/LO.

Parameters:
- TIMEOUT, 64, max cycles in WAIT before abort; must be > engine latency (33).

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- req_valid  input  1  request present
- req_op  input  3  000 NOP, 001 DIV signed, 010 DIVU, 011 MTHI, 100 MTLO; others treated as NOP
- req_a  input  32  dividend / MTHI, MTLO data
- req_b  input  32  divisor
- req_ready  output  1  controller can accept a request this cycle
- mf_req  input  1  pipeline wants to read HI or LO this cycle
- mf_stall  output  1  read must stall
- hi  output  32  HI register (remainder)
- lo  output  32  LO register (quotient)
- div0  output  1  sticky divide-by-zero flag
- timeout_err  output  1  one-cycle pulse on engine abort
- eng_start  output  1  one-cycle launch pulse to engine
- eng_a  output  32  unsigned dividend to engine
- eng_b  output  32  unsigned divisor to engine
- eng_done  input  1  engine result-valid pulse
- eng_q  input  32  engine quotient
- eng_r  input  32  engine remainder

Behaviour:
- Reset (synchronous, at posedge clk with reset=1):
  - state=IDLE; hi=0, lo=0, div0=0, timeout_err=0, eng_start=0, eng_a=0, eng_b=0, internal wait counter=0.
  - Reset mid-divide abandons the operation. A late eng_done arriving in IDLE is ignored.
- Handshake:
  - req_ready=1 only in IDLE.
  - A request is accepted when req_valid && req_ready at a posedge.
  - Any accepted op except NOP clears div0 at that edge.
- FSM states:
  - IDLE:
    - MTHI: hi<=req_a. MTLO: lo<=req_a. Stay IDLE; new value visible the next cycle.
    - DIV/DIVU with req_b==0: div0<=1, hi/lo unchanged, stay IDLE.
    - DIV/DIVU with req_b!=0: latch eng_a/eng_b, go to LAUNCH.
      - DIVU: raw operands.
      - DIV: two's-complement magnitudes. 0x80000000 maps to 0x80000000 as unsigned.
      - Also latch the signed flag, sign_a, and sign_q = sign_a XOR sign_b.
  - LAUNCH: eng_start=1 for exactly this cycle; clear wait counter; go to WAIT.
  - WAIT:
    - On eng_done: capture eng_q/eng_r, go to FIXUP.
    - Otherwise increment the counter. When counter==TIMEOUT-1 and no eng_done: pulse timeout_err for one cycle, hi/lo unchanged, go to IDLE.
    - eng_done takes priority over timeout in the same cycle.
  - FIXUP:
    - lo <= (signed && sign_q) ? -q : q.
    - hi <= (signed && sign_a) ? -r : r.
    - Arithmetic is mod 2^32, so 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
    - Go to IDLE.
- Latency:
  - Divide accepted at edge T: eng_start is high in cycle T+1.
  - If eng_done is seen at edge D, results are written at edge D+1 and visible from cycle D+1 on.
  - MTHI/MTLO: 1 cycle.
- mf_stall = mf_req && (state != IDLE). It is combinational.
  - In IDLE, a same-cycle accepted MTHI/MTLO does not stall the read.
  - Such a read sees the old value; ordering is the pipeline's responsibility.
- Simultaneous events:
  - req_valid outside IDLE is ignored (req_ready=0).
  - eng_done outside WAIT is ignored.

Optional Feature:
- DIV_CTRL_FASTPATH_EN:
  - Defined: in IDLE, an unsigned-magnitude compare |a| < |b| (b!=0) bypasses the engine. lo<=0, hi<=req_a (original signed value) at the accepting edge. State stays IDLE and eng_start never asserts.
  - Undefined: every nonzero-divisor divide goes through LAUNCH/WAIT/FIXUP.

Test Plan:
- DIVU 100/7, engine done after 33 cycles -> one eng_start pulse with eng_a=100, eng_b=7; lo=14, hi=2 one edge after eng_done; req_ready low throughout.
- DIV -7/2 (0xFFFFFFF9/2) -> eng_a=7, eng_b=2; lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- DIV 0x80000000/0xFFFFFFFF -> eng_a=0x80000000, eng_b=1; lo=0x80000000, hi=0.
- DIVU 5/0 -> div0=1 next cycle, hi/lo unchanged, no eng_start; subsequent MTLO 0x1234 clears div0 and sets lo=0x1234.
- Engine never returns eng_done -> timeout_err pulses once TIMEOUT cycles after LAUNCH; hi/lo unchanged; req_ready=1 the cycle after.
- Reset asserted in WAIT with mf_req=1 -> next cycle state IDLE, hi=lo=0, mf_stall=0; late eng_done ignored. With DIV_CTRL_FASTPATH_EN defined, DIVU 3/10 gives lo=0, hi=3 after one edge with no eng_start.
